// File: rtl/ahb_arb_pkg.sv
// Shared encodings and payload types for the two-master AHB-Lite arbiter.
package ahb_arb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned NUM_M  = 2;

   // HTRANS encoding
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   // HBURST encoding
   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_e;

   // Master indices, matching the width of GRANT
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // One master's address-phase bundle
   typedef struct packed {
      logic              hsel;
      logic [1:0]        htrans;
      logic [ADDR_W-1:0] haddr;
      logic              hwrite;
      logic [2:0]        hsize;
      logic [2:0]        hburst;
      logic [3:0]        hprot;
      logic              hmastlock;
   } ahb_addr_t;

   // A transfer is being requested when HTRANS is NONSEQ or SEQ
   function automatic logic htrans_active(input logic [1:0] htrans);
      return htrans[1];
   endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Next-grant decision: hold rules for locked/burst owners, then RR or fixed priority.
module ahb_arb_pick
   import ahb_arb_pkg::*;
#(
   parameter bit ARB_RR = 1'b1
) (
   input  logic       owner_i,
   input  logic [1:0] owner_htrans_i,
   input  logic [2:0] owner_hburst_i,
   input  logic       owner_hmastlock_i,
   input  logic [1:0] req_i,
   output logic       next_grant_c_o
);

   logic other;
   logic hold;

   // The owner keeps the bus through locked sequences and multi-beat bursts
   always_comb begin
      other = ~owner_i;
      hold  = 1'b0;
      if (owner_hmastlock_i && (owner_htrans_i != HTRANS_IDLE)) begin
         hold = 1'b1;
      end
      if ((owner_htrans_i != HTRANS_IDLE) && (owner_hburst_i != HBURST_SINGLE)) begin
         hold = 1'b1;
      end
   end

   // Without a hold, hand over to the other requester (RR) or to the highest priority one
   always_comb begin
      next_grant_c_o = owner_i;
      if (!hold) begin
         if (ARB_RR) begin
            if (req_i[other]) begin
               next_grant_c_o = other;
            end
         end else begin
            if (req_i[M0]) begin
               next_grant_c_o = M0;
            end else if (req_i[M1]) begin
               next_grant_c_o = M1;
            end
         end
      end
   end

endmodule

// File: rtl/ahb_apb_master_arbiter.sv
// Two-master AHB-Lite arbiter/mux feeding the single slave port of the AHB-to-APB bridge.
// The address phase is muxed on GRANT; data-phase signals follow the data-phase owner.
module ahb_apb_master_arbiter
   import ahb_arb_pkg::*;
#(
   parameter bit ARB_RR = 1'b1
) (
   input  logic              HCLK,
   input  logic              HRESETN,
   // master 0
   input  logic              M0_HSEL,
   input  logic [1:0]        M0_HTRANS,
   input  logic [ADDR_W-1:0] M0_HADDR,
   input  logic              M0_HWRITE,
   input  logic [2:0]        M0_HSIZE,
   input  logic [2:0]        M0_HBURST,
   input  logic [3:0]        M0_HPROT,
   input  logic              M0_HMASTLOCK,
   input  logic [DATA_W-1:0] M0_HWDATA,
   output logic [DATA_W-1:0] M0_HRDATA,
   output logic              M0_HREADY,
   output logic              M0_HRESP,
   // master 1
   input  logic              M1_HSEL,
   input  logic [1:0]        M1_HTRANS,
   input  logic [ADDR_W-1:0] M1_HADDR,
   input  logic              M1_HWRITE,
   input  logic [2:0]        M1_HSIZE,
   input  logic [2:0]        M1_HBURST,
   input  logic [3:0]        M1_HPROT,
   input  logic              M1_HMASTLOCK,
   input  logic [DATA_W-1:0] M1_HWDATA,
   output logic [DATA_W-1:0] M1_HRDATA,
   output logic              M1_HREADY,
   output logic              M1_HRESP,
   // bridge slave port
   output logic              S_HSEL,
   output logic [1:0]        S_HTRANS,
   output logic [ADDR_W-1:0] S_HADDR,
   output logic              S_HWRITE,
   output logic [2:0]        S_HSIZE,
   output logic [2:0]        S_HBURST,
   output logic [3:0]        S_HPROT,
   output logic              S_HMASTLOCK,
   output logic [DATA_W-1:0] S_HWDATA,
   output logic              S_HREADYIN,
   input  logic [DATA_W-1:0] S_HRDATA,
   input  logic              S_HREADYOUT,
   input  logic              S_HRESP,
   // debug
   output logic              GRANT
);

   logic      grant_q,  grant_d;
   logic      dvalid_q, dvalid_d;
   logic      downer_q, downer_d;

   ahb_addr_t m0_addr_c;
   ahb_addr_t m1_addr_c;
   ahb_addr_t own_addr_c;
   logic      s_hsel_c;
   logic [1:0] s_htrans_c;
   logic [1:0] req_c;
   logic [1:0] hready_c;
   logic [1:0] hresp_c;
   logic      next_grant_c;

   // Bundle each master's address phase and select the granted one
   always_comb begin
      m0_addr_c.hsel      = M0_HSEL;
      m0_addr_c.htrans    = M0_HTRANS;
      m0_addr_c.haddr     = M0_HADDR;
      m0_addr_c.hwrite    = M0_HWRITE;
      m0_addr_c.hsize     = M0_HSIZE;
      m0_addr_c.hburst    = M0_HBURST;
      m0_addr_c.hprot     = M0_HPROT;
      m0_addr_c.hmastlock = M0_HMASTLOCK;
      m1_addr_c.hsel      = M1_HSEL;
      m1_addr_c.htrans    = M1_HTRANS;
      m1_addr_c.haddr     = M1_HADDR;
      m1_addr_c.hwrite    = M1_HWRITE;
      m1_addr_c.hsize     = M1_HSIZE;
      m1_addr_c.hburst    = M1_HBURST;
      m1_addr_c.hprot     = M1_HPROT;
      m1_addr_c.hmastlock = M1_HMASTLOCK;
      own_addr_c          = (grant_q == M1) ? m1_addr_c : m0_addr_c;
   end

   assign req_c[M0] = M0_HSEL & htrans_active(M0_HTRANS);
   assign req_c[M1] = M1_HSEL & htrans_active(M1_HTRANS);

   // A non-selected owner presents IDLE; reset parks the slave port idle
   assign s_hsel_c   = HRESETN & own_addr_c.hsel;
   assign s_htrans_c = s_hsel_c ? own_addr_c.htrans : HTRANS_IDLE;

   assign S_HSEL      = s_hsel_c;
   assign S_HTRANS    = s_htrans_c;
   assign S_HADDR     = own_addr_c.haddr;
   assign S_HWRITE    = own_addr_c.hwrite;
   assign S_HSIZE     = own_addr_c.hsize;
   assign S_HBURST    = own_addr_c.hburst;
   assign S_HPROT     = own_addr_c.hprot;
   assign S_HMASTLOCK = own_addr_c.hmastlock;
   assign S_HWDATA    = (downer_q == M1) ? M1_HWDATA : M0_HWDATA;
   assign S_HREADYIN  = S_HREADYOUT;

   ahb_arb_pick #(
      .ARB_RR (ARB_RR)
   ) u_pick (
      .owner_i           (grant_q),
      .owner_htrans_i    (own_addr_c.htrans),
      .owner_hburst_i    (own_addr_c.hburst),
      .owner_hmastlock_i (own_addr_c.hmastlock),
      .req_i             (req_c),
      .next_grant_c_o    (next_grant_c)
   );

   // Per-master ready/response: data owner sees the bridge, waiting requester is stalled
   always_comb begin
      hready_c = 2'b11;
      hresp_c  = 2'b00;
      for (int unsigned n = 0; n < NUM_M; n++) begin
         if (!HRESETN) begin
            hready_c[n] = 1'b1;
            hresp_c[n]  = 1'b0;
         end else if (dvalid_q && (downer_q == 1'(n))) begin
            hready_c[n] = S_HREADYOUT;
            hresp_c[n]  = S_HRESP;
         end else if ((grant_q != 1'(n)) && req_c[n]) begin
            hready_c[n] = 1'b0;
         end else if (grant_q == 1'(n)) begin
            hready_c[n] = S_HREADYOUT;
         end
      end
   end

   assign M0_HREADY = hready_c[M0];
   assign M1_HREADY = hready_c[M1];
   assign M0_HRESP  = hresp_c[M0];
   assign M1_HRESP  = hresp_c[M1];
   assign M0_HRDATA = S_HRDATA;
   assign M1_HRDATA = S_HRDATA;
   assign GRANT     = grant_q;

   // Grant and data-phase tracking only move when the bridge accepts a phase
   always_comb begin
      grant_d  = grant_q;
      dvalid_d = dvalid_q;
      downer_d = downer_q;
      if (S_HREADYOUT) begin
         grant_d  = next_grant_c;
         dvalid_d = s_hsel_c & htrans_active(s_htrans_c);
         downer_d = grant_q;
      end
   end

   // Arbiter state registers
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         grant_q  <= M0;
         dvalid_q <= 1'b0;
         downer_q <= M0;
      end else begin
         grant_q  <= grant_d;
         dvalid_q <= dvalid_d;
         downer_q <= downer_d;
      end
   end

endmodule

// File: tb/tb_ahb_apb_master_arbiter.sv
// Bench for ahb_apb_master_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are compared every cycle against a transaction-level model of the arbitration rules.
module tb_ahb_apb_master_arbiter;

   logic HCLK = 1'b0;
   logic HRESETN;
   always #5 HCLK = ~HCLK;

   // Master-side stimulus, index = master number
   logic        sel   [2];
   logic [1:0]  trans [2];
   logic [31:0] addr  [2];
   logic        wr    [2];
   logic [2:0]  size  [2];
   logic [2:0]  burst [2];
   logic [3:0]  prot  [2];
   logic        lock  [2];
   logic [31:0] wdata [2];
   // Bridge-side stimulus
   logic [31:0] s_rdata;
   logic        s_rdyout;
   logic        s_resp;

   // Instance A (round-robin) outputs
   logic [31:0] a_rdata [2];
   logic        a_rdy   [2];
   logic        a_resp  [2];
   logic        a_ssel, a_swr, a_slock, a_srdyin, a_grant;
   logic [1:0]  a_strans;
   logic [31:0] a_saddr, a_swdata;
   logic [2:0]  a_ssize, a_sburst;
   logic [3:0]  a_sprot;
   // Instance B (fixed priority) outputs
   logic [31:0] b_rdata [2];
   logic        b_rdy   [2];
   logic        b_resp  [2];
   logic        b_ssel, b_swr, b_slock, b_srdyin, b_grant;
   logic [1:0]  b_strans;
   logic [31:0] b_saddr, b_swdata;
   logic [2:0]  b_ssize, b_sburst;
   logic [3:0]  b_sprot;

   ahb_apb_master_arbiter #(.ARB_RR(1'b1)) u_rr (
      .HCLK(HCLK), .HRESETN(HRESETN),
      .M0_HSEL(sel[0]), .M0_HTRANS(trans[0]), .M0_HADDR(addr[0]), .M0_HWRITE(wr[0]),
      .M0_HSIZE(size[0]), .M0_HBURST(burst[0]), .M0_HPROT(prot[0]), .M0_HMASTLOCK(lock[0]),
      .M0_HWDATA(wdata[0]), .M0_HRDATA(a_rdata[0]), .M0_HREADY(a_rdy[0]), .M0_HRESP(a_resp[0]),
      .M1_HSEL(sel[1]), .M1_HTRANS(trans[1]), .M1_HADDR(addr[1]), .M1_HWRITE(wr[1]),
      .M1_HSIZE(size[1]), .M1_HBURST(burst[1]), .M1_HPROT(prot[1]), .M1_HMASTLOCK(lock[1]),
      .M1_HWDATA(wdata[1]), .M1_HRDATA(a_rdata[1]), .M1_HREADY(a_rdy[1]), .M1_HRESP(a_resp[1]),
      .S_HSEL(a_ssel), .S_HTRANS(a_strans), .S_HADDR(a_saddr), .S_HWRITE(a_swr),
      .S_HSIZE(a_ssize), .S_HBURST(a_sburst), .S_HPROT(a_sprot), .S_HMASTLOCK(a_slock),
      .S_HWDATA(a_swdata), .S_HREADYIN(a_srdyin), .S_HRDATA(s_rdata),
      .S_HREADYOUT(s_rdyout), .S_HRESP(s_resp), .GRANT(a_grant)
   );

   ahb_apb_master_arbiter #(.ARB_RR(1'b0)) u_fix (
      .HCLK(HCLK), .HRESETN(HRESETN),
      .M0_HSEL(sel[0]), .M0_HTRANS(trans[0]), .M0_HADDR(addr[0]), .M0_HWRITE(wr[0]),
      .M0_HSIZE(size[0]), .M0_HBURST(burst[0]), .M0_HPROT(prot[0]), .M0_HMASTLOCK(lock[0]),
      .M0_HWDATA(wdata[0]), .M0_HRDATA(b_rdata[0]), .M0_HREADY(b_rdy[0]), .M0_HRESP(b_resp[0]),
      .M1_HSEL(sel[1]), .M1_HTRANS(trans[1]), .M1_HADDR(addr[1]), .M1_HWRITE(wr[1]),
      .M1_HSIZE(size[1]), .M1_HBURST(burst[1]), .M1_HPROT(prot[1]), .M1_HMASTLOCK(lock[1]),
      .M1_HWDATA(wdata[1]), .M1_HRDATA(b_rdata[1]), .M1_HREADY(b_rdy[1]), .M1_HRESP(b_resp[1]),
      .S_HSEL(b_ssel), .S_HTRANS(b_strans), .S_HADDR(b_saddr), .S_HWRITE(b_swr),
      .S_HSIZE(b_ssize), .S_HBURST(b_sburst), .S_HPROT(b_sprot), .S_HMASTLOCK(b_slock),
      .S_HWDATA(b_swdata), .S_HREADYIN(b_srdyin), .S_HRDATA(s_rdata),
      .S_HREADYOUT(s_rdyout), .S_HRESP(s_resp), .GRANT(b_grant)
   );

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   // Model state per arbitration policy (0 = round-robin, 1 = fixed):
   // who owns the address bus, and whether a data phase is in flight and for whom.
   int m_own [2];
   bit m_dv  [2];
   int m_dow [2];
   logic last_rdy [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit req(input int n);
      return sel[n] && (trans[n] == 2'd2 || trans[n] == 2'd3);
   endfunction

   // A master sees the bridge while its own data phase runs; a requester that is not the
   // address owner waits; the owner sees the bridge; anyone else is free.
   function automatic logic exp_ready(input int c, input int n);
      if (!HRESETN) return 1'b1;
      if (m_dv[c] && m_dow[c] == n) return s_rdyout;
      if (m_own[c] != n) return req(n) ? 1'b0 : 1'b1;
      return s_rdyout;
   endfunction

   function automatic logic exp_resp(input int c, input int n);
      if (!HRESETN) return 1'b0;
      return (m_dv[c] && m_dow[c] == n) ? s_resp : 1'b0;
   endfunction

   // Who owns the bus after an accepting edge
   function automatic int next_owner(input int c);
      int  o      = m_own[c];
      int  other  = 1 - o;
      bit  locked = lock[o] && trans[o] != 2'd0;
      bit  bursty = trans[o] != 2'd0 && burst[o] != 3'd0;
      if (locked || bursty) return o;
      if (c == 0) return req(other) ? other : o;
      if (req(0)) return 0;
      if (req(1)) return 1;
      return o;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_own[c] = 0;
         m_dv[c]  = 1'b0;
         m_dow[c] = 0;
      end
   endtask

   task automatic check_inst(input string p, input int c, input logic g,
                             input logic r0, input logic r1, input logic e0, input logic e1,
                             input logic [31:0] d0, input logic [31:0] d1, input logic ssel,
                             input logic [1:0] strans, input logic [31:0] saddr,
                             input logic [11:0] sctrl, input logic [31:0] swdata,
                             input logic srdyin);
      int   o    = m_own[c];
      logic esel = HRESETN && sel[o];
      chk({p, ".GRANT"},      32'(g),      32'(o));
      chk({p, ".M0_HREADY"},  32'(r0),     32'(exp_ready(c, 0)));
      chk({p, ".M1_HREADY"},  32'(r1),     32'(exp_ready(c, 1)));
      chk({p, ".M0_HRESP"},   32'(e0),     32'(exp_resp(c, 0)));
      chk({p, ".M1_HRESP"},   32'(e1),     32'(exp_resp(c, 1)));
      chk({p, ".M0_HRDATA"},  d0,          s_rdata);
      chk({p, ".M1_HRDATA"},  d1,          s_rdata);
      chk({p, ".S_HSEL"},     32'(ssel),   32'(esel));
      chk({p, ".S_HTRANS"},   32'(strans), esel ? 32'(trans[o]) : 32'd0);
      chk({p, ".S_HADDR"},    saddr,       addr[o]);
      chk({p, ".S_CTRL"},     32'(sctrl),  32'({wr[o], size[o], burst[o], prot[o], lock[o]}));
      chk({p, ".S_HWDATA"},   swdata,      wdata[m_dow[c]]);
      chk({p, ".S_HREADYIN"}, 32'(srdyin), 32'(s_rdyout));
   endtask

   task automatic check_outputs();
      check_inst("RR", 0, a_grant, a_rdy[0], a_rdy[1], a_resp[0], a_resp[1], a_rdata[0],
                 a_rdata[1], a_ssel, a_strans, a_saddr,
                 {a_swr, a_ssize, a_sburst, a_sprot, a_slock}, a_swdata, a_srdyin);
      check_inst("FIX", 1, b_grant, b_rdy[0], b_rdy[1], b_resp[0], b_resp[1], b_rdata[0],
                 b_rdata[1], b_ssel, b_strans, b_saddr,
                 {b_swr, b_ssize, b_sburst, b_sprot, b_slock}, b_swdata, b_srdyin);
   endtask

   task automatic settle_and_check();
      @(negedge HCLK);
      check_outputs();
   endtask

   // Advance the model across the next rising edge
   task automatic advance();
      int nxt_own [2];
      bit nxt_dv  [2];
      int nxt_dow [2];
      for (int c = 0; c < 2; c++) begin
         nxt_own[c] = m_own[c];
         nxt_dv[c]  = m_dv[c];
         nxt_dow[c] = m_dow[c];
         if (s_rdyout) begin
            nxt_dv[c]  = req(m_own[c]);
            nxt_dow[c] = m_own[c];
            nxt_own[c] = next_owner(c);
         end
      end
      for (int n = 0; n < 2; n++) last_rdy[n] = exp_ready(0, n);
      @(posedge HCLK);
      #1;
      if (!HRESETN) begin
         model_reset();
      end else begin
         for (int c = 0; c < 2; c++) begin
            m_own[c] = nxt_own[c];
            m_dv[c]  = nxt_dv[c];
            m_dow[c] = nxt_dow[c];
         end
      end
   endtask

   task automatic idle_all();
      for (int n = 0; n < 2; n++) begin
         sel[n] = 1'b0; trans[n] = 2'd0; addr[n] = 32'h0; wr[n] = 1'b0; size[n] = 3'd2;
         burst[n] = 3'd0; prot[n] = 4'd3; lock[n] = 1'b0; wdata[n] = 32'h0;
      end
   endtask

   // Masters that were stalled keep their address; others pick a new random phase
   task automatic drive_random();
      for (int n = 0; n < 2; n++) begin
         if (last_rdy[n]) begin
            int r = int'($urandom_range(0, 9));
            sel[n]   = ($urandom_range(0, 7) != 0);
            trans[n] = (r < 3) ? 2'd0 : (r == 3) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
            addr[n]  = $urandom;
            wr[n]    = 1'($urandom);
            size[n]  = 3'($urandom_range(0, 2));
            burst[n] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            prot[n]  = 4'($urandom);
            lock[n]  = ($urandom_range(0, 7) == 0);
            wdata[n] = $urandom;
         end
      end
      s_rdyout = ($urandom_range(0, 3) != 0);
      s_resp   = ($urandom_range(0, 7) == 0);
      s_rdata  = $urandom;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESETN = 1'b0;
      idle_all();
      s_rdyout = 1'b1; s_resp = 1'b0; s_rdata = 32'h0;
      model_reset();
      last_rdy[0] = 1'b1; last_rdy[1] = 1'b1;

      // Reset with no requests
      repeat (2) begin
         settle_and_check();
         advance();
      end
      HRESETN = 1'b1;
      settle_and_check();
      chk("s1.GRANT",     32'(a_grant),  32'd0);
      chk("s1.M0_HREADY", 32'(a_rdy[0]), 32'd1);
      chk("s1.M1_HREADY", 32'(a_rdy[1]), 32'd1);
      chk("s1.S_HTRANS",  32'(a_strans), 32'd0);
      advance();

      // Locked INCR4 read by M0 while M1 waits with a SINGLE
      for (int k = 0; k < 5; k++) begin
         sel[0] = 1'b1; trans[0] = (k == 0) ? 2'd2 : (k < 4) ? 2'd3 : 2'd0;
         burst[0] = 3'd3; lock[0] = (k < 4); wr[0] = 1'b0; addr[0] = 32'h1200_0000 + 32'(4 * k);
         sel[1] = 1'b1; trans[1] = 2'd2; burst[1] = 3'd0; lock[1] = 1'b0; wr[1] = 1'b1;
         addr[1] = 32'h1200_0010; wdata[1] = 32'h0000_00B1;
         settle_and_check();
         chk("s4.GRANT",     32'(a_grant),  32'd0);
         chk("s4.M1_HREADY", 32'(a_rdy[1]), 32'd0);
         advance();
      end
      settle_and_check();
      chk("s4.GRANT_after",     32'(a_grant),  32'd1);
      chk("s4.M1_HREADY_after", 32'(a_rdy[1]), 32'd1);
      advance();

      // Both issue SINGLE together while M1 owns the bus; write data must not cross over
      sel[0] = 1'b1; trans[0] = 2'd2; burst[0] = 3'd0; lock[0] = 1'b0; wr[0] = 1'b1;
      addr[0] = 32'h1200_0020; wdata[0] = 32'h0000_00A0;
      settle_and_check();
      chk("s3.GRANT",     32'(a_grant),  32'd1);
      chk("s3.M0_HREADY", 32'(a_rdy[0]), 32'd0);
      advance();
      trans[1] = 2'd0;
      settle_and_check();
      chk("s3.GRANT_sw",  32'(a_grant),  32'd0);
      chk("s3.S_HWDATA1", a_swdata,      32'h0000_00B1);
      chk("s3.M0_HREADY_sw", 32'(a_rdy[0]), 32'd1);
      advance();
      trans[0] = 2'd0;
      settle_and_check();
      chk("s3.S_HWDATA0", a_swdata,      32'h0000_00A0);
      advance();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive_random();
         settle_and_check();
         advance();
      end

      // M1 single write, then reset during the bridge wait
      idle_all();
      s_rdyout = 1'b1; s_resp = 1'b0;
      sel[1] = 1'b1; trans[1] = 2'd2; wr[1] = 1'b1; addr[1] = 32'h1200_0004;
      for (int k = 0; k < 8 && m_own[0] != 1; k++) begin
         settle_and_check();
         advance();
      end
      settle_and_check();
      chk("s6.GRANT", 32'(a_grant), 32'd1);
      advance();
      trans[1] = 2'd0; wdata[1] = 32'hA5A5_0001; s_rdyout = 1'b0;
      settle_and_check();
      chk("s6.S_HWDATA",  a_swdata,      32'hA5A5_0001);
      chk("s6.M1_HREADY", 32'(a_rdy[1]), 32'd0);
      chk("s6.M0_HREADY", 32'(a_rdy[0]), 32'd1);
      advance();
      #2;
      HRESETN = 1'b0;
      model_reset();
      #1;
      check_outputs();
      chk("s6.GRANT_rst",     32'(a_grant),  32'd0);
      chk("s6.M0_HREADY_rst", 32'(a_rdy[0]), 32'd1);
      chk("s6.M1_HREADY_rst", 32'(a_rdy[1]), 32'd1);
      s_rdyout = 1'b1;
      idle_all();
      repeat (2) begin
         settle_and_check();
         advance();
      end
      HRESETN = 1'b1;

      // M0 read that ends in a bridge error, then a clean M0 read
      sel[0] = 1'b1; trans[0] = 2'd2; wr[0] = 1'b0; addr[0] = 32'h1200_0008;
      settle_and_check();
      chk("s5.M0_HREADY_addr", 32'(a_rdy[0]), 32'd1);
      advance();
      trans[0] = 2'd0; s_rdyout = 1'b0; s_resp = 1'b1;
      settle_and_check();
      chk("s5.M0_HRESP1",  32'(a_resp[0]), 32'd1);
      chk("s5.M0_HREADY1", 32'(a_rdy[0]),  32'd0);
      chk("s5.M1_HRESP1",  32'(a_resp[1]), 32'd0);
      advance();
      s_rdyout = 1'b1;
      settle_and_check();
      chk("s5.M0_HRESP2",  32'(a_resp[0]), 32'd1);
      chk("s5.M0_HREADY2", 32'(a_rdy[0]),  32'd1);
      chk("s5.M1_HRESP2",  32'(a_resp[1]), 32'd0);
      advance();
      s_resp = 1'b0; trans[0] = 2'd2; addr[0] = 32'h1200_000C;
      settle_and_check();
      advance();
      trans[0] = 2'd0; s_rdata = 32'hDEAD_BEEF;
      settle_and_check();
      chk("s6.M0_HRDATA", a_rdata[0],     32'hDEAD_BEEF);
      chk("s6.M0_HRESP",  32'(a_resp[0]), 32'd0);
      chk("s6.M0_HREADY", 32'(a_rdy[0]),  32'd1);
      advance();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
